// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two requesters of dmem_arbiter.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA master.
// The per-port lock inputs exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_valid;
    logic          r0_ready;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r0_err;

    logic          r1_valid;
    logic          r1_ready;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          r1_err;

`ifdef DMEM_ARB_LOCK_EN
    logic          r0_lock;
    logic          r1_lock;
`endif

    // Arbiter side
    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rvalid, r0_rdata, r0_err,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rvalid, r1_rdata, r1_err
`ifdef DMEM_ARB_LOCK_EN
        , input r0_lock, r1_lock
`endif
    );

    // Requester side
    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rvalid, r0_rdata, r0_err,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rvalid, r1_rdata, r1_err
`ifdef DMEM_ARB_LOCK_EN
        , output r0_lock, r1_lock
`endif
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port,
// word-addressed data memory (combinational read, write on posedge).
// Responses are registered and arrive one cycle after the accept.
// Misaligned accesses are accepted but never write and answer with err=1.
// Optional feature macro: DMEM_ARB_LOCK_EN (per-port bus lock / ownership).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    dmem_arbiter_if.slave req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } ownState_e;

    ownState_e     state_q, state_d;
    logic          lastGrant_q, lastGrant_d;
    logic          grant0, grant1;
    logic          accept0, accept1;
    logic          lock0, lock1;
    logic          selWe;
    logic          aligned;

    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [CW-1:0] conflictCnt_q;

`ifdef DMEM_ARB_LOCK_EN
    assign lock0 = req.r0_lock;
    assign lock1 = req.r1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    assign accept0 = req.r0_valid & grant0;
    assign accept1 = req.r1_valid & grant1;

    // Ownership state and round-robin pointer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Next ownership state; the pointer only moves on accepts outside a lock
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        if (accept0 || accept1) begin
            if (state_q == IDLE) begin
                lastGrant_d = accept1;
            end
            if (accept0) begin
                state_d = lock0 ? OWN0 : IDLE;
            end else begin
                state_d = lock1 ? OWN1 : IDLE;
            end
        end else if ((state_q == OWN0) && !req.r0_valid && !lock0) begin
            state_d = IDLE;
        end else if ((state_q == OWN1) && !req.r1_valid && !lock1) begin
            state_d = IDLE;
        end
    end

    // Grant decode: owner only while locked, otherwise round-robin on conflict
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            OWN0: grant0 = req.r0_valid;
            OWN1: grant1 = req.r1_valid;
            default: begin
                if (req.r0_valid && req.r1_valid) begin
                    grant0 = lastGrant_q;
                    grant1 = ~lastGrant_q;
                end else begin
                    grant0 = req.r0_valid;
                    grant1 = req.r1_valid;
                end
            end
        endcase
    end

    // Steer the granted request onto the memory; writes are held off in reset
    always_comb begin
        mem_addr = '0;
        mem_wd   = '0;
        selWe    = 1'b0;
        if (grant0) begin
            mem_addr = req.r0_addr;
            mem_wd   = req.r0_wdata;
            selWe    = req.r0_we;
        end else if (grant1) begin
            mem_addr = req.r1_addr;
            mem_wd   = req.r1_wdata;
            selWe    = req.r1_we;
        end
        aligned = (mem_addr[1:0] == 2'b00);
        mem_we  = selWe & aligned & ~RST;
    end

    // Response contents for the cycle after an accept
    always_comb begin
        rvalid0_d = accept0;
        rvalid1_d = accept1;
        err0_d    = accept0 & ~aligned;
        err1_d    = accept1 & ~aligned;
        rdata0_d  = (accept0 && aligned && !req.r0_we) ? mem_rd : '0;
        rdata1_d  = (accept1 && aligned && !req.r1_we) ? mem_rd : '0;
    end

    // Response registers; reset drops anything in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Saturating count of cycles with both ports requesting
    always_ff @(posedge CLK) begin
        if (RST) begin
            conflictCnt_q <= '0;
        end else if (req.r0_valid && req.r1_valid && (conflictCnt_q != '1)) begin
            conflictCnt_q <= conflictCnt_q + CW'(1);
        end
    end

    assign req.r0_ready  = grant0;
    assign req.r1_ready  = grant1;
    assign req.r0_rvalid = rvalid0_q;
    assign req.r1_rvalid = rvalid1_q;
    assign req.r0_err    = err0_q;
    assign req.r1_err    = err1_q;
    assign req.r0_rdata  = rdata0_q;
    assign req.r1_rdata  = rdata1_q;
    assign conflict_cnt  = conflictCnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, randomized traffic
// against a behavioural model, and a lock sequence when DMEM_ARB_LOCK_EN
// is defined.
module tb_dmem_arbiter;

    typedef struct {
        logic        rst;
        logic        v0, we0, lk0;
        logic [31:0] a0, d0;
        logic        v1, we1, lk1;
        logic [31:0] a1, d1;
    } stimT;

    typedef struct {
        logic        rdy0, rdy1, memWe;
        logic        rv0, rv1, err0, err1;
        logic [31:0] rd0, rd1;
        logic [15:0] cnt;
    } expT;

    typedef struct {
        stimT s;
        expT  e;
    } vecT;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [15:0] conflict_cnt;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .CW(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req          (bus),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .conflict_cnt (conflict_cnt)
    );

    always #5 CLK = ~CLK;

    // Memory attached to the DUT: 64 words, combinational read, posedge write
    logic [31:0] dutMem [64];
    logic        memInit;
    always @(posedge CLK) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) dutMem[i] <= 32'h1000_0000 | 32'(i);
        end else if (mem_we) begin
            dutMem[mem_addr[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = dutMem[mem_addr[7:2]];

    // Reference model state
    logic [31:0] refMem [64];
    int          mLast;
    int          mOwn;
    int          mCnt;

    int          vecCount  = 0;
    int          missCount = 0;
    string       tag;
    vecT         vecs[$];

    function automatic stimT st(logic rst, logic v0, logic we0, logic [31:0] a0, logic [31:0] d0,
                                logic v1, logic we1, logic [31:0] a1, logic [31:0] d1);
        stimT s;
        s.rst = rst;
        s.v0 = v0; s.we0 = we0; s.a0 = a0; s.d0 = d0; s.lk0 = 1'b0;
        s.v1 = v1; s.we1 = we1; s.a1 = a1; s.d1 = d1; s.lk1 = 1'b0;
        return s;
    endfunction

    function automatic expT ex(logic rdy0, logic rdy1, logic memWe, logic rv0, logic rv1,
                               logic err0, logic err1, logic [31:0] rd0, logic [31:0] rd1,
                               logic [15:0] cnt);
        expT e;
        e.rdy0 = rdy0; e.rdy1 = rdy1; e.memWe = memWe;
        e.rv0 = rv0; e.rv1 = rv1; e.err0 = err0; e.err1 = err1;
        e.rd0 = rd0; e.rd1 = rd1; e.cnt = cnt;
        return e;
    endfunction

    task automatic addVec(input stimT s, input expT e);
        vecT v;
        v.s = s;
        v.e = e;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s %s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    // Behavioural model: grant for this cycle, then the state after the edge
    task automatic modelStep(input stimT s, output expT e, output logic [31:0] ea, output logic [31:0] ew);
        logic        v[2], we[2], lk[2];
        logic [31:0] a[2], d[2];
        int          g;
        logic        al;
        v[0] = s.v0; we[0] = s.we0; a[0] = s.a0; d[0] = s.d0;
        v[1] = s.v1; we[1] = s.we1; a[1] = s.a1; d[1] = s.d1;
`ifdef DMEM_ARB_LOCK_EN
        lk[0] = s.lk0; lk[1] = s.lk1;
`else
        lk[0] = 1'b0; lk[1] = 1'b0;
`endif
        if (mOwn >= 0)          g = v[mOwn] ? mOwn : -1;
        else if (v[0] && v[1])  g = 1 - mLast;
        else if (v[0])          g = 0;
        else if (v[1])          g = 1;
        else                    g = -1;

        e = ex(g == 0, g == 1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        ea = (g >= 0) ? a[g] : 32'h0;
        ew = (g >= 0) ? d[g] : 32'h0;
        al = (g >= 0) && (a[g] % 4 == 0);
        e.memWe = (g >= 0) && we[g] && al && !s.rst;

        if (s.rst) begin
            mLast = 1;
            mOwn  = -1;
            mCnt  = 0;
        end else begin
            if (g >= 0) begin
                if (g == 0) begin
                    e.rv0 = 1'b1; e.err0 = !al;
                    e.rd0 = (al && !we[0]) ? refMem[a[0] / 4 % 64] : 32'h0;
                end else begin
                    e.rv1 = 1'b1; e.err1 = !al;
                    e.rd1 = (al && !we[1]) ? refMem[a[1] / 4 % 64] : 32'h0;
                end
                if (e.memWe) refMem[a[g] / 4 % 64] = d[g];
                if (mOwn < 0) mLast = g;
                mOwn = lk[g] ? g : -1;
            end else if (mOwn >= 0 && !v[mOwn] && !lk[mOwn]) begin
                mOwn = -1;
            end
            if (v[0] && v[1] && mCnt < 65535) mCnt++;
        end
        e.cnt = 16'(mCnt);
    endtask

    task automatic applyStimulus(input stimT s);
        @(negedge CLK);
        RST          = s.rst;
        bus.r0_valid = s.v0; bus.r0_we = s.we0; bus.r0_addr = s.a0; bus.r0_wdata = s.d0;
        bus.r1_valid = s.v1; bus.r1_we = s.we1; bus.r1_addr = s.a1; bus.r1_wdata = s.d1;
`ifdef DMEM_ARB_LOCK_EN
        bus.r0_lock  = s.lk0;
        bus.r1_lock  = s.lk1;
`endif
        #1;
    endtask

    task automatic driveCycle(input stimT s, input expT e, input logic [31:0] ea,
                              input logic [31:0] ew, input bit chkBus);
        applyStimulus(s);
        checkOutput("r0_ready", 32'(bus.r0_ready), 32'(e.rdy0));
        checkOutput("r1_ready", 32'(bus.r1_ready), 32'(e.rdy1));
        checkOutput("mem_we", 32'(mem_we), 32'(e.memWe));
        if (chkBus) begin
            checkOutput("mem_addr", mem_addr, ea);
            checkOutput("mem_wd", mem_wd, ew);
        end
    endtask

    task automatic finishCycle(input expT e);
        @(posedge CLK);
        #1;
        checkOutput("r0_rvalid", 32'(bus.r0_rvalid), 32'(e.rv0));
        checkOutput("r1_rvalid", 32'(bus.r1_rvalid), 32'(e.rv1));
        checkOutput("r0_err", 32'(bus.r0_err), 32'(e.err0));
        checkOutput("r1_err", 32'(bus.r1_err), 32'(e.err1));
        checkOutput("r0_rdata", bus.r0_rdata, e.rd0);
        checkOutput("r1_rdata", bus.r1_rdata, e.rd1);
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
    endtask

    initial begin
        stimT        cur;
        stimT        ls;
        expT         me;
        logic [31:0] ea, ew;
        bit          hold0, hold1;

        for (int i = 0; i < 64; i++) refMem[i] = 32'h1000_0000 | 32'(i);
        mLast = 1;
        mOwn  = -1;
        mCnt  = 0;

        // rst v0 we0 a0 d0 | v1 we1 a1 d1  ->  rdy0 rdy1 we | rv0 rv1 err0 err1 rd0 rd1 cnt
        addVec(st(1, 0,0,32'h00,0, 0,0,32'h00,0), ex(0,0,0, 0,0,0,0, 32'h0,32'h0, 0));
        addVec(st(1, 0,0,32'h00,0, 0,0,32'h00,0), ex(0,0,0, 0,0,0,0, 32'h0,32'h0, 0));
        addVec(st(0, 1,0,32'h00,0, 1,0,32'h04,0), ex(1,0,0, 1,0,0,0, 32'h1000_0000,32'h0, 1));
        addVec(st(0, 1,0,32'h00,0, 1,0,32'h04,0), ex(0,1,0, 0,1,0,0, 32'h0,32'h1000_0001, 2));
        addVec(st(0, 1,0,32'h00,0, 1,0,32'h04,0), ex(1,0,0, 1,0,0,0, 32'h1000_0000,32'h0, 3));
        addVec(st(0, 1,0,32'h00,0, 1,0,32'h04,0), ex(0,1,0, 0,1,0,0, 32'h0,32'h1000_0001, 4));
        addVec(st(0, 1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,0), ex(1,0,1, 1,0,0,0, 32'h0,32'h0, 4));
        addVec(st(0, 1,0,32'h10,0, 0,0,32'h0,0), ex(1,0,0, 1,0,0,0, 32'hDEADBEEF,32'h0, 4));
        addVec(st(0, 0,0,32'h0,0, 1,0,32'h13,0), ex(0,1,0, 0,1,0,1, 32'h0,32'h0, 4));
        addVec(st(0, 0,0,32'h0,0, 1,1,32'h12,32'h12345678), ex(0,1,0, 0,1,0,1, 32'h0,32'h0, 4));
        addVec(st(0, 1,0,32'h10,0, 0,0,32'h0,0), ex(1,0,0, 1,0,0,0, 32'hDEADBEEF,32'h0, 4));
        addVec(st(0, 1,1,32'h20,32'hA5A5A5A5, 0,0,32'h0,0), ex(1,0,1, 1,0,0,0, 32'h0,32'h0, 4));
        addVec(st(0, 0,0,32'h0,0, 1,0,32'h20,0), ex(0,1,0, 0,1,0,0, 32'h0,32'hA5A5A5A5, 4));
        addVec(st(0, 1,0,32'h10,0, 0,0,32'h0,0), ex(1,0,0, 1,0,0,0, 32'hDEADBEEF,32'h0, 4));
        addVec(st(1, 1,0,32'h10,0, 0,0,32'h0,0), ex(1,0,0, 0,0,0,0, 32'h0,32'h0, 0));
        addVec(st(1, 0,0,32'h0,0, 1,1,32'h20,32'h0BADF00D), ex(0,1,0, 0,0,0,0, 32'h0,32'h0, 0));
        addVec(st(0, 0,0,32'h0,0, 1,0,32'h20,0), ex(0,1,0, 0,1,0,0, 32'h0,32'hA5A5A5A5, 0));
        addVec(st(0, 1,0,32'h00,0, 1,0,32'h04,0), ex(1,0,0, 1,0,0,0, 32'h1000_0000,32'h0, 1));
        addVec(st(0, 0,0,32'h0,0, 0,0,32'h0,0), ex(0,0,0, 0,0,0,0, 32'h0,32'h0, 1));
        addVec(st(0, 0,0,32'h0,0, 0,0,32'h0,0), ex(0,0,0, 0,0,0,0, 32'h0,32'h0, 1));

        // Fill the memory while reset is held
        RST = 1'b1;
        memInit = 1'b1;
        applyStimulus(st(1, 0,0,0,0, 0,0,0,0));
        @(posedge CLK);
        #1;
        memInit = 1'b0;

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            modelStep(vecs[i].s, me, ea, ew);
            driveCycle(vecs[i].s, vecs[i].e, ea, ew, 1'b0);
            finishCycle(vecs[i].e);
        end

        // Randomized traffic; requests are held until accepted
        hold0 = 1'b0;
        hold1 = 1'b0;
        cur = st(0, 0,0,0,0, 0,0,0,0);
        for (int n = 0; n < 400; n++) begin
            tag = $sformatf("rnd%0d", n);
            if (!hold0) begin
                cur.v0  = ($urandom_range(0, 99) < 60);
                cur.we0 = 1'($urandom_range(0, 1));
                cur.a0  = randAddr();
                cur.d0  = $urandom;
                cur.lk0 = ($urandom_range(0, 2) == 0);
            end
            if (!hold1) begin
                cur.v1  = ($urandom_range(0, 99) < 60);
                cur.we1 = 1'($urandom_range(0, 1));
                cur.a1  = randAddr();
                cur.d1  = $urandom;
                cur.lk1 = ($urandom_range(0, 2) == 0);
            end
            cur.rst = ($urandom_range(0, 59) == 0);
            modelStep(cur, me, ea, ew);
            driveCycle(cur, me, ea, ew, 1'b1);
            finishCycle(me);
            hold0 = cur.v0 && !me.rdy0;
            hold1 = cur.v1 && !me.rdy1;
        end

`ifdef DMEM_ARB_LOCK_EN
        // Port 1 takes the lock, holds it for three cycles, then releases
        tag = "lock_reset";
        ls = st(1, 0,0,0,0, 0,0,0,0);
        modelStep(ls, me, ea, ew);
        driveCycle(ls, me, ea, ew, 1'b1);
        finishCycle(me);

        tag = "lock_take";
        ls = st(0, 0,0,0,0, 1,0,32'h04,0);
        ls.lk1 = 1'b1;
        modelStep(ls, me, ea, ew);
        driveCycle(ls, me, ea, ew, 1'b1);
        checkOutput("r1_ready_lock", 32'(bus.r1_ready), 32'd1);
        finishCycle(me);

        for (int k = 0; k < 3; k++) begin
            tag = $sformatf("lock_hold%0d", k);
            ls = st(0, 1,0,32'h00,0, 1,0,32'h08,0);
            ls.lk1 = 1'b1;
            modelStep(ls, me, ea, ew);
            driveCycle(ls, me, ea, ew, 1'b1);
            checkOutput("r0_blocked", 32'(bus.r0_ready), 32'd0);
            finishCycle(me);
        end

        tag = "lock_release";
        ls = st(0, 1,0,32'h00,0, 1,0,32'h08,0);
        modelStep(ls, me, ea, ew);
        driveCycle(ls, me, ea, ew, 1'b1);
        checkOutput("r0_blocked", 32'(bus.r0_ready), 32'd0);
        finishCycle(me);

        tag = "lock_after";
        ls = st(0, 1,0,32'h00,0, 0,0,0,0);
        modelStep(ls, me, ea, ew);
        driveCycle(ls, me, ea, ew, 1'b1);
        checkOutput("r0_granted", 32'(bus.r0_ready), 32'd1);
        finishCycle(me);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
